// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Top-level scheduler for the PE-array inference flow. It walks the weight
// index, the input row and the layer. It also issues load requests to the
// dataload unit and drives the PE array control strobes. When the final layer
// has rounded, it presents the inference result through a valid/ready
// handshake.
//
// All outputs are Moore decodes of the registered state plus the registered
// counters. There is no combinational path from any input to any output.
//
// Ports:
//   clk                    single clock, rising edge
//   rst                    asynchronous active-high reset
//   start_i                begin an inference (sampled only in IDLE)
//   abort_i                synchronous abort, returns to IDLE from any state
//   weight_req_o           request weight load from dataload
//   weight_valid_i         weight load complete
//   input_req_o            request next input row (layer 0 only)
//   input_valid_i          input row loaded
//   array_keep_o           PE array holds accumulators
//   array_rounder_en_o     PE array rounder enable
//   array_rounder_valid_i  rounder finished
//   array_input_type_o     0 = external input, 1 = feedback
//   weight_number_o        current weight index
//   input_load_number_o    current input row
//   layer_number_o         current layer
//   busy_o                 high in every state except IDLE
//   result_valid_o         inference result available
//   result_ready_i         consumer accepts result
// -----------------------------------------------------------------------------
module layer_sequencer #(
  parameter int N_WEIGHT = 8,
  parameter int N_ROW    = 16,
  parameter int N_LAYER  = 8,
  localparam int WW = (N_WEIGHT > 1) ? $clog2(N_WEIGHT) : 1,
  localparam int RW = (N_ROW    > 1) ? $clog2(N_ROW)    : 1,
  localparam int LW = (N_LAYER  > 1) ? $clog2(N_LAYER)  : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          weight_req_o,
  input  logic          weight_valid_i,
  output logic          input_req_o,
  input  logic          input_valid_i,
  output logic          array_keep_o,
  output logic          array_rounder_en_o,
  input  logic          array_rounder_valid_i,
  output logic          array_input_type_o,
  output logic [WW-1:0] weight_number_o,
  output logic [RW-1:0] input_load_number_o,
  output logic [LW-1:0] layer_number_o,
  output logic          busy_o,
  output logic          result_valid_o,
  input  logic          result_ready_i
);

  localparam logic [WW-1:0] W_LAST = WW'(N_WEIGHT - 1);
  localparam logic [RW-1:0] R_LAST = RW'(N_ROW - 1);
  localparam logic [LW-1:0] L_LAST = LW'(N_LAYER - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    LOAD_IN = 3'd2,
    COMPUTE = 3'd3,
    ROUND   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state_reg,  state_next;
  logic [WW-1:0] weight_reg, weight_next;
  logic [RW-1:0] row_reg,    row_next;
  logic [LW-1:0] layer_reg,  layer_next;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      weight_reg <= '0;
      row_reg    <= '0;
      layer_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      weight_reg <= weight_next;
      row_reg    <= row_next;
      layer_reg  <= layer_next;
    end
  end

  // Next-state, counter update and Moore output decode
  always_comb begin
    state_next         = state_reg;
    weight_next        = weight_reg;
    row_next           = row_reg;
    layer_next         = layer_reg;
    weight_req_o       = 1'b0;
    input_req_o        = 1'b0;
    array_keep_o       = 1'b0;
    array_rounder_en_o = 1'b0;
    array_input_type_o = 1'b0;
    busy_o             = 1'b1;
    result_valid_o     = 1'b0;

    case (state_reg)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_next = LOAD_W;
      end

      LOAD_W: begin
        weight_req_o       = 1'b1;
        array_input_type_o = (layer_reg != '0);
        if (weight_valid_i) state_next = (layer_reg == '0) ? LOAD_IN : COMPUTE;
      end

      LOAD_IN: begin
        input_req_o        = 1'b1;
        array_keep_o       = 1'b1;
        array_input_type_o = (layer_reg != '0);
        if (input_valid_i) state_next = COMPUTE;
      end

      COMPUTE: begin
        array_input_type_o = (layer_reg != '0);
        if (weight_reg == W_LAST) begin
          weight_next = '0;
          if (row_reg == R_LAST) begin
            row_next   = '0;
            state_next = ROUND;
          end else begin
            row_next = row_reg + 1'b1;
            // Only layer 0 fetches external rows. Later layers consume the
            // fed-back data back-to-back.
            state_next = (layer_reg == '0) ? LOAD_IN : COMPUTE;
          end
        end else begin
          weight_next = weight_reg + 1'b1;
        end
      end

      ROUND: begin
        array_rounder_en_o = 1'b1;
        array_input_type_o = (layer_reg != '0);
        if (array_rounder_valid_i) begin
          if (layer_reg == L_LAST) begin
            state_next = DONE;
          end else begin
            layer_next = layer_reg + 1'b1;
            state_next = LOAD_W;
          end
        end
      end

      DONE: begin
        result_valid_o = 1'b1;
        if (result_ready_i) begin
          state_next  = IDLE;
          weight_next = '0;
          row_next    = '0;
          layer_next  = '0;
        end
      end

      default: begin
        state_next  = IDLE;
        weight_next = '0;
        row_next    = '0;
        layer_next  = '0;
      end
    endcase

    // Abort overrides every transition, including a start request in IDLE.
    if (abort_i) begin
      state_next  = IDLE;
      weight_next = '0;
      row_next    = '0;
      layer_next  = '0;
    end
  end

  assign weight_number_o     = weight_reg;
  assign input_load_number_o = row_reg;
  assign layer_number_o      = layer_reg;

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Top-level scheduler for the PE-array inference flow.
- Walks weight index (0..N_WEIGHT-1), input row (0..N_ROW-1) and layer (0..N_LAYER-1).
- Issues load requests to the dataload unit and drives the array control strobes (keep, rounder enable, input type).
- Presents a result-valid/ready handshake once the final layer has rounded.

Parameters:
- N_WEIGHT, 8, weight tiles per input row (COMPUTE cycles per row).
- N_ROW, 16, input rows per layer.
- N_LAYER, 8, layers per inference.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  begin an inference; sampled only in IDLE.
- abort_i  in  1  synchronous abort; returns to IDLE from any state.
- weight_req_o  out  1  request weight load from dataload.
- weight_valid_i  in  1  weight load complete.
- input_req_o  out  1  request next input row, used in layer 0 only.
- input_valid_i  in  1  input row loaded.
- array_keep_o  out  1  PE array holds accumulators.
- array_rounder_en_o  out  1  PE array rounder enable.
- array_rounder_valid_i  in  1  rounder finished.
- array_input_type_o  out  1  0 = external input (layer 0), 1 = feedback (layers >0).
- weight_number_o  out  clog2(N_WEIGHT)  current weight index.
- input_load_number_o  out  clog2(N_ROW)  current input row.
- layer_number_o  out  clog2(N_LAYER)  current layer.
- busy_o  out  1  high in every state except IDLE.
- result_valid_o  out  1  inference result available.
- result_ready_i  in  1  consumer accepts result.

Behaviour:
- Reset (async, rst=1): state=IDLE, all counters 0, all outputs 0.
- Outputs are Moore decodes of the registered state plus registered counters. No input-to-output combinational paths.
- States and outputs:
  - IDLE: all strobes 0. start_i=1 -> LOAD_W.
  - LOAD_W: weight_req_o=1. On weight_valid_i: if layer==0 -> LOAD_IN, else -> COMPUTE.
  - LOAD_IN: input_req_o=1, array_keep_o=1. On input_valid_i -> COMPUTE.
  - COMPUTE: weight counter increments every cycle.
    - At weight==N_WEIGHT-1: weight wraps to 0.
    - If row<N_ROW-1: row+1; next state is LOAD_IN when layer==0, otherwise stay in COMPUTE.
    - If row==N_ROW-1: row wraps to 0 -> ROUND.
  - ROUND: array_rounder_en_o=1. Hold until array_rounder_valid_i.
    - If layer<N_LAYER-1: layer+1 -> LOAD_W.
    - Else -> DONE.
  - DONE: result_valid_o=1, held until result_ready_i. Then -> IDLE with all counters cleared.
- array_input_type_o = (layer_number_o != 0) in LOAD_W/LOAD_IN/COMPUTE/ROUND; 0 in IDLE and DONE.
- Valid inputs are ignored in states that do not wait on them.
- A valid asserted in the same cycle as entering the waiting state is not seen; it is sampled from the next cycle onward.
- Minimum residency is 1 cycle per LOAD_W/LOAD_IN/ROUND visit.
- Cycle cost when valids are already high on the first waiting cycle:
  - Layer 0: 1 + N_ROW*(1+N_WEIGHT) + 1.
  - Each other layer: 1 + N_ROW*N_WEIGHT + 1.
  - Defaults: 146 + 7*130 = 1056 cycles from the start-sampling edge until result_valid_o rises.
- start_i outside IDLE: ignored. No queuing.
- abort_i: has priority over every transition, including start_i in IDLE. Next state IDLE, counters 0, result_valid_o drops.
- rst mid-operation: immediate return to reset values, independent of clk.
- Counters never exceed their parameter limits. Wrap to 0 is the only overflow path.

Test Plan:
- Reset: rst=1 during COMPUTE -> all outputs 0 asynchronously; state IDLE after release.
- Full run with weight_valid_i/input_valid_i/array_rounder_valid_i tied 1 and result_ready_i=0, start_i pulsed 1 cycle -> result_valid_o rises 1056 cycles after the start-sampling edge, with layer_number_o=7 and busy_o=1 throughout. Raising result_ready_i -> IDLE next cycle, all counters 0.
- Layer 0 input loading: input_valid_i delayed 3 cycles per row -> input_req_o and array_keep_o high 4 cycles per row. Exactly 16 input requests occur, each followed by weight_number_o sequence 0..7 and input_load_number_o stepping 0..15.
- Layer 1 continuity: after the first ROUND -> LOAD_W once, then 128 consecutive COMPUTE cycles with array_input_type_o=1 and input_req_o never asserted.
- Rounder stall: array_rounder_valid_i held 0 for 10 cycles in ROUND -> array_rounder_en_o stays 1, counters frozen. Asserting valid on layer 7 -> DONE.
- Abort/start conflict: abort_i=1 with start_i=1 in IDLE -> remains IDLE. abort_i mid-COMPUTE (layer 2, row 5, weight 3) -> IDLE next cycle, all counters 0; a new start_i restarts from layer 0.
